// File: rtl/mpmc9_write_seq.sv
// Single-port write sequencer: converts a (address, length) request into
// per-beat UI data writes, each followed by its write command, then a done pulse.
module mpmc9_write_seq #(
  parameter int DATA_W   = 128,
  parameter int ADDR_W   = 29,
  parameter int BEAT_INC = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  calib_done,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_adr,
  input  logic [2:0]            req_len,
  input  logic                  wd_valid,
  output logic                  wd_ready,
  input  logic [DATA_W-1:0]     wd_data,
  input  logic [DATA_W/8-1:0]   wd_sel,
  output logic                  app_en,
  output logic [2:0]            app_cmd,
  output logic [ADDR_W-1:0]     app_addr,
  input  logic                  app_rdy,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  output logic [DATA_W-1:0]     app_wdf_data,
  output logic [DATA_W/8-1:0]   app_wdf_mask,
  input  logic                  app_wdf_rdy,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE,
    WLOAD,
    WDATA,
    WCMD,
    DONE
  } state_t;

  state_t                state_q;
  logic [ADDR_W-1:0]     adr_q;
  logic [2:0]            len_q;
  logic [2:0]            beat_q;
  logic [DATA_W-1:0]     dat_q;
  logic [DATA_W/8-1:0]   msk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      adr_q   <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      dat_q   <= '0;
      msk_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && calib_done) begin
            adr_q   <= req_adr;
            len_q   <= req_len;
            beat_q  <= '0;
            state_q <= WLOAD;
          end
        end
        WLOAD: begin
          if (wd_valid) begin
            dat_q   <= wd_data;
            msk_q   <= ~wd_sel;
            state_q <= WDATA;
          end
        end
        WDATA: begin
          if (app_wdf_rdy) state_q <= WCMD;
        end
        WCMD: begin
          if (app_rdy) begin
            if (beat_q == len_q) begin
              state_q <= DONE;
            end else begin
              // Address wraps modulo 2^ADDR_W by truncation of the sum.
              adr_q   <= adr_q + ADDR_W'(BEAT_INC);
              beat_q  <= beat_q + 3'd1;
              state_q <= WLOAD;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // req_ready is gated by rst_n so that every output reads 0 while reset is held.
  assign req_ready    = rst_n && calib_done && (state_q == IDLE);
  assign wd_ready     = (state_q == WLOAD);
  assign app_wdf_wren = (state_q == WDATA);
  assign app_wdf_end  = (state_q == WDATA);
  assign app_wdf_data = (state_q == WDATA) ? dat_q : '0;
  assign app_wdf_mask = (state_q == WDATA) ? msk_q : '0;
  assign app_en       = (state_q == WCMD);
  assign app_cmd      = 3'b000;
  assign app_addr     = (state_q == WCMD) ? adr_q : '0;
  assign done         = (state_q == DONE);

endmodule
